// File: rtl/encoder_pkg.sv
// ============================================================================
// Module  : encoder_pkg
// Purpose : Shared state type and default sizing for the rotary step decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package encoder_pkg;

  // Encoding mirrors the filtered (A,B) level pair that selects each state.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CCW   = 2'b01,
    CW    = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam int unsigned c_WIDTH_DEFAULT      = 8;
  localparam int unsigned c_DEB_CYCLES_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/sync_debounce.sv
// ============================================================================
// Module  : sync_debounce
// Purpose : 2-FF synchroniser for one encoder level, followed by a stability
//           filter when DEBOUNCE_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_debounce
  import encoder_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = c_DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], d_i};
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned c_CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic               filt_q, filt_d;
  logic [c_CNT_W-1:0] cnt_q,  cnt_d;

  // The counter holds how many consecutive edges have already seen disagreement.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == c_CNT_W'(DEB_CYCLES - 1)) filt_d = sync_q[1];
      else                                   cnt_d  = cnt_q + c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q_o = filt_q;
`else
  logic deb_cycles_unused;
  assign deb_cycles_unused = |DEB_CYCLES;
  assign q_o               = sync_q[1];
`endif

endmodule

`default_nettype wire

// File: rtl/rotary_step_decoder.sv
// ============================================================================
// Module  : rotary_step_decoder
// Purpose : Classifies filtered A/B direction levels into steps and keeps a
//           saturating position. Optional input filter: DEBOUNCE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rotary_step_decoder
  import encoder_pkg::*;
#(
  parameter int unsigned WIDTH      = c_WIDTH_DEFAULT,
  parameter int unsigned MAX_POS    = 255,
  parameter int unsigned DEB_CYCLES = c_DEB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             clr,
  output logic [WIDTH-1:0] pos,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             dir,
  output logic             err,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] c_MAX_POS = WIDTH'(MAX_POS);

  logic fa, fb;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sync_a (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (A),
    .q_o  (fa)
  );

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sync_b (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (B),
    .q_o  (fb)
  );

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pos_q,   pos_d;
  logic             cw_q,    cw_d;
  logic             ccw_q,   ccw_d;
  logic             dir_q,   dir_d;
  logic             err_q,   err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cw_q    <= 1'b0;
      ccw_q   <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cw_q    <= cw_d;
      ccw_q   <= ccw_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cw_d    = 1'b0;
    ccw_d   = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;

    // FAULT absorbs single-direction levels; only 00 releases it.
    case ({fa, fb})
      2'b11: begin
        state_d = FAULT;
        err_d   = 1'b1;
      end
      2'b10: begin
        if (state_q == IDLE || state_q == CCW) begin
          state_d = CW;
          cw_d    = 1'b1;
          dir_d   = 1'b1;
          if (pos_q < c_MAX_POS) pos_d = pos_q + WIDTH'(1);
        end
      end
      2'b01: begin
        if (state_q == IDLE || state_q == CW) begin
          state_d = CCW;
          ccw_d   = 1'b1;
          dir_d   = 1'b0;
          if (pos_q != '0) pos_d = pos_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  assign pos      = pos_q;
  assign step_cw  = cw_q;
  assign step_ccw = ccw_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign at_min   = (pos_q == '0);
  assign at_max   = (pos_q == c_MAX_POS);

endmodule

`default_nettype wire

// File: tb/tb_rotary_step_decoder.sv
// ============================================================================
// Module  : tb_rotary_step_decoder
// Purpose : Directed and random stimulus against a cycle-level behavioural
//           model of the rotary step decoder. Honours DEBOUNCE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rotary_step_decoder;

  localparam int W    = 4;
  localparam int MAXP = 5;
  localparam int DEB  = 4;
`ifdef DEBOUNCE_EN
  localparam int HOLD = DEB + 2;
`else
  localparam int HOLD = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n, A, B, clr;
  logic [W-1:0] pos;
  logic         step_cw, step_ccw, dir, err, at_min, at_max;

  rotary_step_decoder #(.WIDTH(W), .MAX_POS(MAXP), .DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .clr     (clr),
    .pos     (pos),
    .step_cw (step_cw),
    .step_ccw(step_ccw),
    .dir     (dir),
    .err     (err),
    .at_min  (at_min),
    .at_max  (at_max)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: inputs sampled two edges ago are what the step logic sees.
  int       m_pos;
  bit       m_cw, m_ccw, m_dir, m_err;
  bit [1:0] m_last;
  bit [1:0] m_h1, m_h2;
  bit [1:0] m_filt;
  int       m_run [2];

  task automatic model_reset();
    m_pos = 0; m_cw = 0; m_ccw = 0; m_dir = 0; m_err = 0;
    m_last = 2'b00; m_h1 = 2'b00; m_h2 = 2'b00; m_filt = 2'b00;
    m_run[0] = 0; m_run[1] = 0;
  endtask

  task automatic model_edge(input bit a, input bit b, input bit c);
    bit [1:0] lvl;
`ifdef DEBOUNCE_EN
    lvl = m_filt;
    for (int i = 0; i < 2; i++) begin
      if (m_h2[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_filt[i] = m_h2[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
`else
    lvl = m_h2;
`endif
    m_cw = 0; m_ccw = 0;
    if (lvl == 2'b11) begin
      m_err  = 1;
      m_last = 2'b11;
    end else if (m_last == 2'b11) begin
      if (lvl == 2'b00) m_last = 2'b00;
    end else begin
      if (lvl == 2'b10 && m_last != 2'b10) begin
        m_cw = 1; m_dir = 1;
        if (m_pos < MAXP) m_pos = m_pos + 1;
      end
      if (lvl == 2'b01 && m_last != 2'b01) begin
        m_ccw = 1; m_dir = 0;
        if (m_pos > 0) m_pos = m_pos - 1;
      end
      m_last = lvl;
    end
    if (c) begin
      m_pos = 0;
      m_err = 0;
    end
    m_h2 = m_h1;
    m_h1 = {a, b};
  endtask

  task automatic check_all();
    chk_value("pos",      32'(pos),      32'(m_pos));
    chk_value("step_cw",  32'(step_cw),  32'(m_cw));
    chk_value("step_ccw", 32'(step_ccw), 32'(m_ccw));
    chk_value("dir",      32'(dir),      32'(m_dir));
    chk_value("err",      32'(err),      32'(m_err));
    chk_value("at_min",   32'(at_min),   32'(m_pos == 0));
    chk_value("at_max",   32'(at_max),   32'(m_pos == MAXP));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit a, input bit b, input bit c);
    A = a; B = b; clr = c;
    @(posedge clk);
    model_edge(a, b, c);
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    for (int i = 0; i < n; i++) cycle(a, b, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    for (int i = 0; i < n; i++) begin
      A = ~A;
      @(posedge clk);
      #1 check_all();
      @(negedge clk);
    end
    A = 1'b0; B = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    A = 1'b0; B = 1'b0; clr = 1'b0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(4);
    hold(0, 0, 5);

    for (int k = 0; k < 3; k++) begin
      hold(1, 0, HOLD);
      hold(0, 0, 3);
    end
`ifndef DEBOUNCE_EN
    chk_value("three_cw_pos", 32'(pos), 32'd3);
`endif

    hold(1, 0, HOLD + 1);
    hold(0, 1, HOLD + 1);
    hold(0, 0, HOLD + 2);

    hold(1, 1, HOLD);
    hold(0, 1, HOLD);
    hold(0, 0, HOLD + 1);
    hold(0, 1, HOLD);
    hold(0, 0, HOLD + 2);
    chk_value("fault_err_set", 32'(err), 32'd1);
    cycle(0, 0, 1'b1);
    hold(0, 0, 1);
    chk_value("clr_err", 32'(err), 32'd0);

    for (int k = 0; k < 7; k++) begin
      hold(1, 0, HOLD);
      hold(0, 0, HOLD);
    end
    hold(0, 0, 4);
    chk_value("sat_max", 32'(at_max), 32'd1);
    cycle(0, 0, 1'b1);
    hold(0, 1, HOLD);
    hold(0, 0, HOLD + 3);
    chk_value("sat_min", 32'(at_min), 32'd1);

    hold(1, 0, 3);
    hold(0, 0, 8);
    hold(1, 0, 6);
    hold(0, 0, 8);

    for (int s = 0; s < 300; s++) begin
      int r, len;
      bit [1:0] p;
      r = int'($urandom_range(0, 15));
      if (r == 0)      p = 2'b11;
      else if (r < 6)  p = 2'b10;
      else if (r < 11) p = 2'b01;
      else             p = 2'b00;
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++)
        cycle(p[1], p[0], ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 59) == 0) do_reset(int'($urandom_range(1, 3)));
    end
    hold(0, 0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
